// File: rtl/sparrow_dmem_ctrl.sv
// Load/store bridge from the core to a DATA_W-wide data memory; misaligned accesses become two beats.
// Latency 3 cycles (+2 when split), per-beat grant backpressure, response timeout raises o_err.
package sparrow_dmem_pkg;
  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF_WORD = 2'd1,
    WORD      = 2'd2
  } mem_access_size_e;
endpackage

module sparrow_dmem_ctrl
  import sparrow_dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic [31:0]           i_addr,
  input  mem_access_size_e      i_size,
  input  logic                  i_wr_en,
  input  logic [31:0]           i_wr_data,
  input  logic                  i_zero_extend,
  output logic                  o_rd_valid,
  output logic [31:0]           o_rd_data,
  output logic                  o_err,
  output logic                  o_dmem_req,
  input  logic                  i_dmem_gnt,
  output logic [31:0]           o_dmem_addr,
  output logic [DATA_W/8-1:0]   o_dmem_be,
  output logic                  o_dmem_wr_en,
  output logic [DATA_W-1:0]     o_dmem_wr_data,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_W-1:0]     i_dmem_rd_data
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]             r_state;
  logic [31:0]            r_addr;
  mem_access_size_e       r_size;
  logic                   r_wr_en;
  logic [31:0]            r_wr_data;
  logic                   r_zext;
  logic                   r_split;
  logic                   r_beat;
  logic [CNT_W-1:0]       r_tmo;
  logic [2*DATA_W-1:0]    r_asm;
  logic                   r_rd_valid;
  logic [31:0]            r_rd_data;
  logic                   r_err;

  logic [OFF_W-1:0]       w_in_off;
  logic [4:0]             w_in_n;
  logic [4:0]             w_in_end;
  logic                   w_in_split;
  logic [OFF_W-1:0]       w_off;
  logic [2*BE_W-1:0]      w_mask;
  logic [2*BE_W-1:0]      w_be_full;
  logic [2*DATA_W-1:0]    w_wd_full;
  logic [31:0]            w_base;
  logic [31:0]            w_beat_addr;
  logic [BE_W-1:0]        w_beat_be;
  logic [DATA_W-1:0]      w_beat_wd;
  logic                   w_issue;
  logic [2*DATA_W-1:0]    w_asm_nxt;
  logic [31:0]            w_raw;
  logic [31:0]            w_load_data;

  // Split decision is made from the incoming request so it is ready for beat 0.
  assign w_in_off   = i_addr[OFF_W-1:0];
  always_comb begin
    w_in_n = 5'd4;
    case (i_size)
      BYTE:      w_in_n = 5'd1;
      HALF_WORD: w_in_n = 5'd2;
      default:   w_in_n = 5'd4;
    endcase
  end
  assign w_in_end   = 5'(w_in_off) + w_in_n;
  assign w_in_split = (w_in_end > 5'(BE_W));

  assign w_off = r_addr[OFF_W-1:0];
  always_comb begin
    w_mask = (2*BE_W)'(15);
    case (r_size)
      BYTE:      w_mask = (2*BE_W)'(1);
      HALF_WORD: w_mask = (2*BE_W)'(3);
      default:   w_mask = (2*BE_W)'(15);
    endcase
  end

  // Lower half of the shifted strobes/data is beat 0, upper half spills into beat 1.
  assign w_be_full   = w_mask << w_off;
  assign w_wd_full   = (2*DATA_W)'(r_wr_data) << {w_off, 3'b000};
  assign w_base      = {r_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign w_beat_addr = r_beat ? (w_base + 32'(BE_W)) : w_base;
  assign w_beat_be   = r_beat ? w_be_full[2*BE_W-1:BE_W] : w_be_full[BE_W-1:0];
  assign w_beat_wd   = r_beat ? w_wd_full[2*DATA_W-1:DATA_W] : w_wd_full[DATA_W-1:0];

  assign w_issue        = (r_state == S_ISSUE);
  assign o_ready        = (r_state == S_IDLE);
  assign o_dmem_req     = w_issue;
  assign o_dmem_addr    = w_issue ? w_beat_addr : 32'd0;
  assign o_dmem_be      = w_issue ? w_beat_be : '0;
  assign o_dmem_wr_en   = w_issue & r_wr_en;
  assign o_dmem_wr_data = w_issue ? w_beat_wd : '0;

  always_comb begin
    w_asm_nxt = r_asm;
    if ((r_state == S_RESP) && i_dmem_rvalid) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_beat_be[i]) begin
          if (r_beat) w_asm_nxt[DATA_W + 8*i +: 8] = i_dmem_rd_data[8*i +: 8];
          else        w_asm_nxt[8*i +: 8]          = i_dmem_rd_data[8*i +: 8];
        end
      end
    end
  end

  // Shifting the two-beat window down by the offset puts the bytes in address order.
  assign w_raw = 32'(w_asm_nxt >> {w_off, 3'b000});

  always_comb begin
    w_load_data = w_raw;
    case (r_size)
      BYTE:      w_load_data = r_zext ? {24'd0, w_raw[7:0]} : {{24{w_raw[7]}}, w_raw[7:0]};
      HALF_WORD: w_load_data = r_zext ? {16'd0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
      default:   w_load_data = w_raw;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'd0;
      r_size     <= BYTE;
      r_wr_en    <= 1'b0;
      r_wr_data  <= 32'd0;
      r_zext     <= 1'b0;
      r_split    <= 1'b0;
      r_beat     <= 1'b0;
      r_tmo      <= '0;
      r_asm      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_addr    <= i_addr;
            r_size    <= i_size;
            r_wr_en   <= i_wr_en;
            r_wr_data <= i_wr_data;
            r_zext    <= i_zero_extend;
            r_split   <= w_in_split;
            r_beat    <= 1'b0;
            r_asm     <= '0;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_dmem_gnt) begin
            r_tmo   <= '0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_dmem_rvalid) begin
            r_asm <= w_asm_nxt;
            if (r_split && !r_beat) begin
              r_beat  <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_state    <= S_IDLE;
              r_rd_valid <= 1'b1;
              r_rd_data  <= r_wr_en ? 32'd0 : w_load_data;
            end
          end else if (r_tmo == CNT_W'(TIMEOUT - 1)) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_err      = r_err;

  a_done_excl: assert property (@(posedge i_clk) disable iff (i_rst) !(o_rd_valid && o_err));
  a_req_has_be: assert property (@(posedge i_clk) disable iff (i_rst) o_dmem_req |-> (o_dmem_be != '0));

endmodule

// File: tb/tb_sparrow_dmem_ctrl.sv
// Scoreboard bench for sparrow_dmem_ctrl (DATA_W=32, TIMEOUT=16): table-driven accesses,
// bench-side memory responder, beat and result expectations queued at drive time.
module tb_sparrow_dmem_ctrl;
  import sparrow_dmem_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int NV      = 12;
  localparam int RST_AT  = 11;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req;
  logic                   ready;
  logic [31:0]            addr;
  mem_access_size_e       size;
  logic                   wr_en;
  logic [31:0]            wr_data;
  logic                   zext;
  logic                   rd_valid;
  logic [31:0]            rd_data;
  logic                   err;
  logic                   dmem_req;
  logic                   dmem_gnt;
  logic [31:0]            dmem_addr;
  logic [3:0]             dmem_be;
  logic                   dmem_wr_en;
  logic [31:0]            dmem_wr_data;
  logic                   dmem_rvalid;
  logic [31:0]            dmem_rd_data;

  always #5 clk = ~clk;

  sparrow_dmem_ctrl #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .o_ready(ready),
    .i_addr(addr), .i_size(size), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_zero_extend(zext), .o_rd_valid(rd_valid), .o_rd_data(rd_data), .o_err(err),
    .o_dmem_req(dmem_req), .i_dmem_gnt(dmem_gnt), .o_dmem_addr(dmem_addr),
    .o_dmem_be(dmem_be), .o_dmem_wr_en(dmem_wr_en), .o_dmem_wr_data(dmem_wr_data),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rd_data(dmem_rd_data)
  );

  typedef struct {
    logic [31:0]      addr;
    mem_access_size_e size;
    logic             wr;
    logic [31:0]      wd;
    logic             zx;
    int               g;
    int               r;
    logic             noise;
    logic             err;
    logic [31:0]      rd0;
    logic [31:0]      rd1;
    logic [31:0]      exp;
    logic             split;
    logic [31:0]      a0;
    logic [3:0]       be0;
    logic [31:0]      w0;
    logic [31:0]      a1;
    logic [3:0]       be1;
    logic [31:0]      w1;
  } vec_t;

  typedef struct { logic [31:0] a; logic [3:0] be; logic wr; logic [31:0] w; } beat_t;
  typedef struct { logic err; logic [31:0] data; } res_t;

  vec_t  tbl [NV];
  beat_t bq [$];
  res_t  rq [$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_val_seen = 0;
  int n_err_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) n_val_seen++;
      if (err)      n_err_seen++;
    end
  end

  task automatic run_vec(input int i);
    vec_t  v;
    beat_t bt;
    res_t  rs;
    int    nb;
    int    acc;
    int    exp_lat;
    v  = tbl[i];
    nb = v.split ? 2 : 1;
    check_eq($sformatf("v%0d_ready", i), 32'(ready), 32'd1);
    bq.push_back('{v.a0, v.be0, v.wr, v.w0});
    if (v.split) bq.push_back('{v.a1, v.be1, v.wr, v.w1});
    rq.push_back('{v.err, v.exp});
    req = 1'b1; addr = v.addr; size = v.size; wr_en = v.wr; wr_data = v.wd; zext = v.zx;
    acc = cyc;
    tick();
    req = 1'b0;
    for (int b = 0; b < nb; b++) begin
      for (int d = 0; d <= v.g; d++) begin
        bt = bq[0];
        check_eq($sformatf("v%0d_b%0d_req", i, b), 32'(dmem_req), 32'd1);
        check_eq($sformatf("v%0d_b%0d_addr", i, b), dmem_addr, bt.a);
        check_eq($sformatf("v%0d_b%0d_be", i, b), 32'(dmem_be), 32'(bt.be));
        check_eq($sformatf("v%0d_b%0d_wr", i, b), 32'(dmem_wr_en), 32'(bt.wr));
        check_eq($sformatf("v%0d_b%0d_wd", i, b), dmem_wr_data, bt.w);
        dmem_gnt     = (d == v.g);
        dmem_rvalid  = v.noise;
        dmem_rd_data = v.noise ? 32'hFFFF_FFFF : 32'd0;
        tick();
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      void'(bq.pop_front());
      if (v.err) break;
      for (int d = 0; d <= v.r; d++) begin
        if (d == v.r) begin
          dmem_rvalid  = 1'b1;
          dmem_gnt     = 1'b0;
          dmem_rd_data = (b == 1) ? v.rd1 : v.rd0;
        end else begin
          dmem_rvalid  = 1'b0;
          dmem_gnt     = v.noise;
        end
        tick();
      end
      dmem_rvalid = 1'b0; dmem_gnt = 1'b0;
    end
    for (int k = 0; k < 64 && !rd_valid && !err; k++) tick();
    exp_lat = v.err ? (2 + v.g + TIMEOUT) : (1 + nb * (v.g + v.r + 2));
    rs = rq.pop_front();
    check_eq($sformatf("v%0d_lat", i), 32'(cyc - acc), 32'(exp_lat));
    check_eq($sformatf("v%0d_err", i), 32'(err), 32'(rs.err));
    check_eq($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(!rs.err));
    if (!rs.err) check_eq($sformatf("v%0d_data", i), rd_data, rs.data);
    check_eq($sformatf("v%0d_ready_done", i), 32'(ready), 32'd1);
    tick();
    check_eq($sformatf("v%0d_valid_pulse", i), 32'(rd_valid), 32'd0);
    check_eq($sformatf("v%0d_err_pulse", i), 32'(err), 32'd0);
    if (!rs.err) check_eq($sformatf("v%0d_data_hold", i), rd_data, rs.data);
  endtask

  task automatic reset_test();
    req = 1'b1; addr = 32'h0000_03FE; size = WORD; wr_en = 1'b0; wr_data = 32'd0; zext = 1'b0;
    tick();
    req = 1'b0;
    check_eq("rst_issue_req", 32'(dmem_req), 32'd1);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check_eq("rst_in_resp", 32'(ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_req", 32'(dmem_req), 32'd0);
    check_eq("rst_be", 32'(dmem_be), 32'd0);
    check_eq("rst_wr_en", 32'(dmem_wr_en), 32'd0);
    check_eq("rst_addr", dmem_addr, 32'd0);
    check_eq("rst_wdata", dmem_wr_data, 32'd0);
    check_eq("rst_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rdata", rd_data, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("rst_no_beat1_%0d", k), 32'(dmem_req), 32'd0);
    end
  endtask

  initial begin
    int exp_val;
    int exp_err;
    //        addr          size       wr  wd            zx g  r  nz err rd0           rd1           exp           sp a0            be0     w0            a1            be1     w1
    tbl[0]  = '{32'h100, WORD,      0, 32'h0,        0, 0, 0, 0, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0};
    tbl[1]  = '{32'h103, BYTE,      0, 32'h0,        0, 0, 0, 0, 0, 32'h80000000, 32'h0,        32'hFFFFFF80, 0, 32'h100, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0};
    tbl[2]  = '{32'h103, BYTE,      0, 32'h0,        1, 0, 0, 0, 0, 32'h80000000, 32'h0,        32'h00000080, 0, 32'h100, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0};
    tbl[3]  = '{32'h102, WORD,      1, 32'h11223344, 0, 0, 0, 0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        1, 32'h100, 4'b1100, 32'h33440000, 32'h104, 4'b0011, 32'h00001122};
    tbl[4]  = '{32'h103, HALF_WORD, 0, 32'h0,        0, 0, 0, 0, 0, 32'hAB000000, 32'h00000080, 32'hFFFF80AB, 1, 32'h100, 4'b1000, 32'h0,        32'h104, 4'b0001, 32'h0};
    tbl[5]  = '{32'h102, HALF_WORD, 0, 32'h0,        1, 0, 0, 0, 0, 32'h80017777, 32'h0,        32'h00008001, 0, 32'h100, 4'b1100, 32'h0,        32'h0,   4'b0000, 32'h0};
    tbl[6]  = '{32'h100, HALF_WORD, 0, 32'h0,        0, 0, 0, 0, 0, 32'h12348765, 32'h0,        32'hFFFF8765, 0, 32'h100, 4'b0011, 32'h0,        32'h0,   4'b0000, 32'h0};
    tbl[7]  = '{32'h101, BYTE,      1, 32'h000000A5, 0, 2, 3, 1, 0, 32'h0,        32'h0,        32'h0,        0, 32'h100, 4'b0010, 32'h0000A500, 32'h0,   4'b0000, 32'h0};
    tbl[8]  = '{32'h200, WORD,      0, 32'h0,        0, 5, 0, 0, 1, 32'h0,        32'h0,        32'h0,        0, 32'h200, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0};
    tbl[9]  = '{32'h3FE, WORD,      0, 32'h0,        0, 1, 2, 1, 0, 32'hBEEF1111, 32'h2222CAFE, 32'hCAFEBEEF, 1, 32'h3FC, 4'b1100, 32'h0,        32'h400, 4'b0011, 32'h0};
    tbl[10] = '{32'h101, BYTE,      0, 32'h0,        0, 0, 0, 0, 0, 32'h00007F00, 32'h0,        32'h0000007F, 0, 32'h100, 4'b0010, 32'h0,        32'h0,   4'b0000, 32'h0};
    tbl[11] = '{32'h106, HALF_WORD, 1, 32'h9999BBBB, 0, 0, 1, 0, 0, 32'h0,        32'h0,        32'h0,        0, 32'h104, 4'b1100, 32'hBBBB0000, 32'h0,   4'b0000, 32'h0};

    rst = 1'b1; req = 1'b0; addr = 32'd0; size = BYTE; wr_en = 1'b0; wr_data = 32'd0; zext = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rd_data = 32'd0;
    repeat (3) tick();
    check_eq("reset_ready", 32'(ready), 32'd1);
    check_eq("reset_req", 32'(dmem_req), 32'd0);
    check_eq("reset_valid", 32'(rd_valid), 32'd0);
    check_eq("reset_err", 32'(err), 32'd0);
    check_eq("reset_rdata", rd_data, 32'd0);
    rst = 1'b0;
    tick();

    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rd_data = 32'h1234_5678;
    repeat (2) tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    check_eq("idle_noise_req", 32'(dmem_req), 32'd0);
    check_eq("idle_noise_valid", 32'(rd_valid), 32'd0);
    check_eq("idle_noise_ready", 32'(ready), 32'd1);

    exp_val = 0;
    exp_err = 0;
    for (int i = 0; i < NV; i++) begin
      if (i == RST_AT) reset_test();
      run_vec(i);
      if (tbl[i].err) exp_err++;
      else            exp_val++;
    end
    tick();
    check_eq("total_valid_pulses", 32'(n_val_seen), 32'(exp_val));
    check_eq("total_err_pulses", 32'(n_err_seen), 32'(exp_err));
    check_eq("queues_drained", 32'(bq.size() + rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sparrow_dmem_ctrl.md
SPARROW_DMEM_CTRL -- requirements
Module: sparrow_dmem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, memory bus width in bits; SHALL be 32 or 64; BE_W = DATA_W/8.
REQ-002 Parameter TIMEOUT, default 16, max cycles waiting for i_dmem_rvalid per beat; SHALL be >= 2.
REQ-003 i_clk  in  1  single clock, all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  core access request.
REQ-006 o_ready  out  1  controller idle and accepting; request accepted when i_req && o_ready.
REQ-007 i_addr  in  32  byte address, any alignment.
REQ-008 i_size  in  mem_access_size_e  BYTE / HALF_WORD / WORD = 1 / 2 / 4 bytes.
REQ-009 i_wr_en  in  1  1 = store, 0 = load.
REQ-010 i_wr_data  in  32  store data, right-justified.
REQ-011 i_zero_extend  in  1  load extension: 1 zero, 0 sign.
REQ-012 o_rd_valid  out  1  one-cycle pulse: access complete (load data valid, or store acknowledged).
REQ-013 o_rd_data  out  32  extended load data; 0 for stores.
REQ-014 o_err  out  1  one-cycle pulse: access aborted by timeout.
REQ-015 o_dmem_req / i_dmem_gnt  out / in  1 / 1  memory request / grant.
REQ-016 o_dmem_addr  out  32  BE_W-aligned beat address.
REQ-017 o_dmem_be  out  BE_W  byte-lane strobes.
REQ-018 o_dmem_wr_en / o_dmem_wr_data  out  1 / DATA_W  beat write flag / lane-steered write data.
REQ-019 i_dmem_rvalid / i_dmem_rd_data  in  1 / DATA_W  beat response (loads and stores) / read data.

Function
REQ-020 FSM states IDLE, ISSUE, RESP; o_ready = (state == IDLE).
REQ-021 On acceptance: latch addr, size, wr_en, wr_data, zero_extend; compute off = addr mod BE_W, n = size bytes; split = (off + n > BE_W); go to ISSUE with beat 0.
REQ-022 ISSUE: o_dmem_req = 1; addr/be/wr_en/wr_data constant until i_dmem_gnt; on gnt go to RESP.
REQ-023 Beat 0: o_dmem_addr = addr with low log2(BE_W) bits cleared; o_dmem_be = ((1<<n)-1) << off, truncated to BE_W; wr_data = latched data << 8*off, truncated.
REQ-024 Beat 1 (split only): o_dmem_addr = beat-0 address + BE_W; o_dmem_be = remaining low bytes; wr_data = remaining upper bytes of latched data at lane 0.
REQ-025 RESP: on i_dmem_rvalid capture enabled lanes into an assembly register; if split and beat 0, go to ISSUE for beat 1, else go to IDLE and pulse o_rd_valid in the next cycle.
REQ-026 Minimum latency: accept cycle 0, req+gnt cycle 1, rvalid cycle 2, o_rd_valid cycle 3 (o_ready high in cycle 3); split adds 2 cycles.
REQ-027 Load result: assembled bytes in address order, extended from bit 8n-1 per i_zero_extend; WORD not extended.
REQ-028 o_rd_data and o_rd_valid are registered; o_rd_data holds its value until the next completion.
REQ-029 Timeout counter resets on entry to RESP; TIMEOUT cycles in RESP without rvalid -> o_err pulse next cycle, go to IDLE, no o_rd_valid, beat 1 never issued.
REQ-030 i_dmem_rvalid outside RESP and i_dmem_gnt outside ISSUE SHALL be ignored.
REQ-031 Simultaneous gnt and rvalid in ISSUE: gnt takes effect, rvalid ignored.
REQ-032 i_req while not ready SHALL be ignored; the core holds it.

Reset
REQ-033 i_rst in any state, including mid split: state IDLE, o_ready 1, o_dmem_req 0, o_dmem_be 0, o_dmem_wr_en 0, o_dmem_addr 0, o_dmem_wr_data 0, o_rd_valid 0, o_rd_data 0, o_err 0, counters 0, pending beat discarded.

Verification (DATA_W = 32)
REQ-034 WORD load at 0x100, gnt immediate, rvalid next cycle, data 0xDEADBEEF -> be 4'b1111, o_rd_valid at cycle 3, o_rd_data 0xDEADBEEF.
REQ-035 BYTE signed load at 0x103, rd_data 0x80000000 -> be 4'b1000, o_rd_data 0xFFFFFF80; with zero-extend 0x00000080.
REQ-036 WORD store at 0x102, data 0x11223344 -> beat 0 addr 0x100, be 4'b1100, wdata 0x33440000; beat 1 addr 0x104, be 4'b0011, wdata 0x00001122; one o_rd_valid after beat 1.
REQ-037 HALF_WORD signed load at 0x103, beat 0 data 0xAB000000, beat 1 data 0x00000080 -> o_rd_data 0xFFFF80AB.
REQ-038 Gnt withheld 5 cycles -> o_dmem_req/addr/be/wdata stable all 5 cycles; no rvalid for TIMEOUT=16 cycles -> single o_err pulse, o_ready returns, no o_rd_valid.
REQ-039 i_rst asserted in RESP of split beat 0 -> next cycle all outputs at reset values, no beat 1 issued, next request completes normally.
